// File: rtl/uart_tx_drain.sv
// Purpose     : drains an upstream byte FIFO onto an RS-485 UART line (start, 8 data LSB first,
//               optional parity, 1 stop) and closes each burst with a silence of SILENCE_BITS bit times.
// Latency     : FIFO pop 1 clk after IDLE sees data; start bit 2 clks after the pop; all outputs registered.
// Backpressure: pops only while tx_enable=1 and fifo_empty=0; never pops in GAP; a dropped tx_enable
//               lets the byte on the wire finish, then the silence gap runs.
//
// Ports
//   clk, n_reset        : single clock, asynchronous active-low reset
//   fifo_empty          : upstream FIFO empty flag
//   fifo_data[7:0]      : upstream FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en          : one-cycle pop strobe (high only in FETCH)
//   tx_enable           : permits starting new bytes
//   baud_div[15:0]      : clocks per bit, latched when a burst starts, floored at MIN_DIV
//   parity_en/odd       : parity insertion and sense, sampled once per byte in LOAD
//   txd                 : serial line, idle high
//   de                  : RS-485 driver enable, high from burst start until the silence gap
//   busy                : high whenever the engine is not IDLE
//   frame_done          : one-cycle pulse when the silence gap has elapsed
module uart_tx_drain #(
    parameter int unsigned SILENCE_BITS = 39,
    parameter int unsigned MIN_DIV      = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    input  logic        tx_enable,
    input  logic [15:0] baud_div,
    input  logic        parity_en,
    input  logic        parity_odd,
    output logic        txd,
    output logic        de,
    output logic        busy,
    output logic        frame_done
);

    // The gap counter must cover SILENCE_BITS bit times at the slowest divisor without wrapping.
    localparam int unsigned        GAP_W     = $clog2(SILENCE_BITS * 65535 + 1);
    localparam logic [15:0]        MIN_DIV_W = 16'(MIN_DIV);
    localparam logic [GAP_W-1:0]   SILENCE_W = GAP_W'(SILENCE_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6,
        GAP    = 3'd7
    } state_t;

    state_t           state_q,      state_d;
    logic [15:0]      div_q,        div_d;        // divisor latched for the whole burst
    logic [15:0]      div_cnt_q,    div_cnt_d;    // clocks elapsed in the current bit
    logic [3:0]       bit_cnt_q,    bit_cnt_d;    // data bit index
    logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;    // clocks elapsed in the silence gap
    logic [7:0]       shift_q,      shift_d;      // data bits, current bit in [0]
    logic             par_bit_q,    par_bit_d;
    logic             par_en_q,     par_en_d;

    logic             txd_q,        txd_d;
    logic             de_q,         de_d;
    logic             rd_en_q,      rd_en_d;
    logic             busy_q,       busy_d;
    logic             frame_done_q, frame_done_d;

    logic             can_fetch;
    logic             bit_end;
    logic             gap_end;
    logic [GAP_W-1:0] gap_len;

    assign can_fetch = tx_enable & ~fifo_empty;
    assign bit_end   = (div_cnt_q == div_q - 16'd1);
    assign gap_len   = SILENCE_W * GAP_W'(div_q);
    assign gap_end   = (gap_cnt_q == gap_len - GAP_W'(1));

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        par_en_d     = par_en_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_fetch) begin
                    state_d = FETCH;
                    div_d   = (baud_div < MIN_DIV_W) ? MIN_DIV_W : baud_div;
                end
            end

            // Pop strobe is high during this single cycle; data shows up in LOAD.
            FETCH: begin
                state_d = LOAD;
            end

            LOAD: begin
                shift_d   = fifo_data;
                par_bit_d = (^fifo_data) ^ parity_odd;
                par_en_d  = parity_en;
                div_cnt_d = 16'd0;
                state_d   = START;
            end

            START: begin
                if (bit_end) begin
                    div_cnt_d = 16'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = DATA;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    div_cnt_d = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end

            PARITY: begin
                if (bit_end) begin
                    div_cnt_d = 16'd0;
                    state_d   = STOP;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end

            // Back-to-back bytes skip the gap; FETCH+LOAD then stretch the stop bit by two clocks.
            STOP: begin
                if (bit_end) begin
                    div_cnt_d = 16'd0;
                    if (can_fetch) begin
                        state_d = FETCH;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end

            // The FIFO is deliberately ignored here: new data waits for IDLE.
            GAP: begin
                if (gap_end) begin
                    gap_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_bit_d;
            default: txd_d = 1'b1;
        endcase
        de_d    = (state_d != IDLE) && (state_d != GAP);
        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            div_q        <= MIN_DIV_W;
            div_cnt_q    <= 16'd0;
            bit_cnt_q    <= 4'd0;
            gap_cnt_q    <= '0;
            shift_q      <= 8'd0;
            par_bit_q    <= 1'b0;
            par_en_q     <= 1'b0;
            txd_q        <= 1'b1;
            de_q         <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            par_en_q     <= par_en_d;
            txd_q        <= txd_d;
            de_q         <= de_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign txd        = txd_q;
    assign de         = de_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: the reference expands each byte into a per-clock list of expected
// output vectors (txd, de, rd_en, busy, frame_done); the checker compares every clock.
module tb_uart_tx_drain;

    localparam int SIL     = 39;
    localparam int MIN_DIV = 4;
    localparam int LOGN    = 65536;

    logic        clk        = 1'b0;
    logic        n_reset    = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data  = 8'h00;
    logic        fifo_rd_en;
    logic        tx_enable  = 1'b0;
    logic [15:0] baud_div   = 16'd16;
    logic        parity_en  = 1'b0;
    logic        parity_odd = 1'b0;
    logic        txd, de, busy, frame_done;

    uart_tx_drain #(.SILENCE_BITS(SIL), .MIN_DIV(MIN_DIV)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx_enable  (tx_enable),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .txd        (txd),
        .de         (de),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic txd;
        logic de;
        logic rd;
        logic busy;
        logic fd;
    } exp_t;

    localparam exp_t E_IDLE = 5'b10000;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       plan[$];
    exp_t       cur   = E_IDLE;
    int         m_mode = 0;   // 0: idle, 1: after a stop bit, 2: fetched, bits not yet planned
    int         m_div  = MIN_DIV;
    logic [7:0] m_byte = 8'h00;
    logic       m_par;
    logic [7:0] fifo_q[$];
    int         pops[$];
    int         fds[$];
    logic       txd_log [0:LOGN-1];
    logic       de_log  [0:LOGN-1];

    function automatic exp_t mk(input logic t, input logic d, input logic r, input logic b, input logic f);
        mk = {t, d, r, b, f};
    endfunction

    task automatic push_n(input exp_t e, input int n);
        for (int i = 0; i < n; i++) plan.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: expands bytes and gaps into per-clock expectations.
    initial forever begin
        @(posedge clk or negedge n_reset);
        if (!n_reset) begin
            plan.delete();
            m_mode = 0;
            cur    = E_IDLE;
        end else begin
            if (plan.size() == 0) begin
                if (m_mode == 2) begin
                    m_par = (^m_byte) ^ parity_odd;
                    push_n(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0), m_div);
                    for (int b = 0; b < 8; b++) push_n(mk(m_byte[b], 1'b1, 1'b0, 1'b1, 1'b0), m_div);
                    if (parity_en) push_n(mk(m_par, 1'b1, 1'b0, 1'b1, 1'b0), m_div);
                    push_n(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), m_div);
                    m_mode = 1;
                end else if (tx_enable && !fifo_empty) begin
                    if (m_mode == 0) m_div = (int'(baud_div) < MIN_DIV) ? MIN_DIV : int'(baud_div);
                    m_byte = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
                    plan.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
                    plan.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
                    m_mode = 2;
                end else if (m_mode == 1) begin
                    push_n(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), SIL * m_div);
                    plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
                    m_mode = 0;
                end
            end
            if (plan.size() > 0) cur = plan.pop_front();
            else                 cur = E_IDLE;
        end
    end

    // Per-cycle checker plus event logs for the directed checks.
    initial forever begin
        @(negedge clk);
        total++;
        if ({txd, de, fifo_rd_en, busy, frame_done} !== cur) begin
            bad++;
            $display("FAIL cycle_compare @%0d: txd/de/rd/busy/fd=%b required %b",
                     cyc, {txd, de, fifo_rd_en, busy, frame_done}, cur);
        end
        if (cyc < LOGN) begin
            txd_log[cyc] = txd;
            de_log[cyc]  = de;
        end
        if (fifo_rd_en === 1'b1) pops.push_back(cyc);
        if (frame_done === 1'b1) fds.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // All stimulus waits go through here so the FIFO model sees every pop strobe.
    task automatic tick();
        @(negedge clk);
        if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) tick();
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
        tick();
    endtask

    task automatic wait_pop(input int want, input int budget);
        int n;
        n = 0;
        while (pops.size() < want && n < budget) begin
            tick();
            n++;
        end
        if (pops.size() < want) begin
            total++;
            bad++;
            $display("FAIL wait_pop: pops=%0d, required %0d", pops.size(), want);
        end
    endtask

    function automatic int pop_at(input int idx);
        pop_at = (pops.size() > idx) ? pops[idx] : 0;
    endfunction

    function automatic int de_run(input int from, input int to);
        de_run = 1;
        for (int i = from; i <= to; i++) if (de_log[i] !== 1'b1) de_run = 0;
    endfunction

    int         p0, f0, c, r_cyc, r;
    logic [9:0] a5_bits = 10'b11_0100_1010;
    logic [5:0] d_pat   = 6'b100001;

    initial begin
        #1 n_reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs", int'({txd, de, fifo_rd_en, busy, frame_done}), 5'b10000);
        n_reset = 1'b1;
        repeat (2) tick();

        // 0xA5 at 16 clocks/bit, no parity
        baud_div = 16'd16; parity_en = 1'b0; tx_enable = 1'b1;
        p0 = pops.size(); f0 = fds.size();
        push(8'hA5);
        wait_idle(2000);
        check("A_pop_count", pops.size() - p0, 1);
        c = pop_at(p0);
        for (int k = 0; k < 10; k++)
            check($sformatf("A_bit%0d", k), int'(txd_log[c + 2 + 16 * k + 8]), int'(a5_bits[k]));
        check("A_de_high", de_run(c, c + 161), 1);
        check("A_fd_count", fds.size() - f0, 1);
        check("A_fd_offset", (fds.size() > f0) ? fds[f0] - c : -1, 786);

        // parity on byte 0x07 at the minimum divisor
        baud_div = 16'd4; parity_en = 1'b1; parity_odd = 1'b0;
        p0 = pops.size();
        push(8'h07);
        wait_idle(2000);
        c = pop_at(p0);
        check("B_even_parity", int'(txd_log[c + 2 + 36 + 2]), 1);
        parity_odd = 1'b1;
        p0 = pops.size();
        push(8'h07);
        wait_idle(2000);
        c = pop_at(p0);
        check("B_odd_parity", int'(txd_log[c + 2 + 36 + 2]), 0);

        // three bytes back to back at 8 clocks/bit
        baud_div = 16'd8; parity_en = 1'b0; parity_odd = 1'b0;
        p0 = pops.size(); f0 = fds.size();
        push(8'h3C); push(8'h81); push(8'hFF);
        wait_idle(3000);
        check("C_pop_count", pops.size() - p0, 3);
        check("C_spacing1", pop_at(p0 + 1) - pop_at(p0), 82);
        check("C_spacing2", pop_at(p0 + 2) - pop_at(p0 + 1), 82);
        check("C_de_continuous", de_run(pop_at(p0), pop_at(p0 + 2) + 81), 1);
        check("C_fd_count", fds.size() - f0, 1);
        check("C_fd_offset", (fds.size() > f0) ? fds[f0] - pop_at(p0 + 2) : -1, 394);

        // divisor below the floor, then changed mid-frame
        baud_div = 16'd2;
        p0 = pops.size(); f0 = fds.size();
        push(8'hFF);
        repeat (3) tick();
        baud_div = 16'd30;
        wait_idle(2000);
        c = pop_at(p0);
        for (int i = 0; i < 6; i++)
            check($sformatf("D_start_bit%0d", i), int'(txd_log[c + 1 + i]), int'(d_pat[i]));
        check("D_fd_offset", (fds.size() > f0) ? fds[f0] - c : -1, 198);

        // reset during data bit 3, second byte still queued
        baud_div = 16'd8;
        p0 = pops.size(); f0 = fds.size();
        push(8'h00); push(8'h55);
        wait_pop(p0 + 1, 20);
        c = pop_at(p0);
        for (int n = 0; n < 100 && cyc < c + 37; n++) tick();
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1 check("E_async_reset", int'({txd, de, fifo_rd_en, busy, frame_done}), 5'b10000);
        tick(); tick();
        r_cyc   = cyc;
        n_reset = 1'b1;
        wait_pop(p0 + 2, 20);
        check("E_refetch_delay", pop_at(p0 + 1) - r_cyc, 1);
        wait_idle(2000);
        check("E_fresh_start", int'(txd_log[pop_at(p0 + 1) + 2]), 0);
        check("E_fd_count", fds.size() - f0, 1);

        // tx_enable dropped during byte 1 of 2
        baud_div = 16'd4;
        p0 = pops.size(); f0 = fds.size();
        push(8'h11); push(8'h22);
        wait_pop(p0 + 1, 20);
        repeat (10) tick();
        tx_enable = 1'b0;
        wait_idle(2000);
        check("F_single_pop", pops.size() - p0, 1);
        check("F_fd_count", fds.size() - f0, 1);
        tx_enable = 1'b1;
        wait_idle(2000);
        check("F_resume_pop", pops.size() - p0, 2);

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            baud_div   = 16'($urandom_range(0, 9));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            tx_enable  = 1'b1;
            r = $urandom_range(1, 3);
            for (int j = 0; j < r; j++) push(8'($urandom));
            for (int t = 0; t < 150; t++) begin
                tick();
                r = $urandom_range(0, 99);
                if (r < 2)       push(8'($urandom));
                else if (r < 4)  tx_enable = ~tx_enable;
                else if (r < 6)  baud_div = 16'($urandom_range(0, 12));
                else if (r < 8)  parity_en = ~parity_en;
                else if (r == 8) parity_odd = ~parity_odd;
            end
            tx_enable = 1'b1;
            wait_idle(6000);
        end

        tx_enable = 1'b1;
        for (int g = 0; g < 10 && (fifo_q.size() > 0 || busy !== 1'b0); g++) wait_idle(6000);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter SILENCE_BITS, default 39, inter-frame silence in bit times (3.5 characters of 11 bits).
REQ-002 Parameter MIN_DIV, default 4, lowest permitted clocks-per-bit.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  empty flag of upstream transmit FIFO.
REQ-006 fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 fifo_rd_en  output  1  one-cycle FIFO pop strobe.
REQ-008 tx_enable  input  1  permits starting new bytes.
REQ-009 baud_div  input  16  clocks per bit.
REQ-010 parity_en  input  1  insert parity bit.
REQ-011 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-012 txd  output  1  serial line, idle high.
REQ-013 de  output  1  RS-485 driver enable.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at end of inter-frame silence.

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP and GAP.
REQ-017 IDLE -> FETCH SHALL occur when tx_enable=1 and fifo_empty=0.
REQ-018 fifo_rd_en SHALL be high only in FETCH, for exactly one cycle.
REQ-019 LOAD SHALL capture fifo_data into the shift register, compute parity, then go to START.
REQ-020 On IDLE -> FETCH, baud_div SHALL be latched; a latched value below MIN_DIV SHALL be replaced by MIN_DIV.
REQ-021 The latched divisor SHALL stay constant until the block returns to IDLE.
REQ-022 Each of START, DATA (per bit), PARITY and STOP SHALL last exactly the latched divisor in clocks.
REQ-023 txd SHALL be 0 in START; LSB first in DATA (8 bits); parity in PARITY; 1 in STOP.
REQ-024 PARITY SHALL be skipped when parity_en=0; parity_en and parity_odd SHALL be sampled in LOAD.
REQ-025 Parity bit SHALL be XOR of the data bits, inverted when parity_odd=1.
REQ-026 At STOP end, if fifo_empty=0 and tx_enable=1, the FSM SHALL go to FETCH (back-to-back, 2-cycle stop extension); otherwise it SHALL go to GAP.
REQ-027 de SHALL rise on entry to FETCH from IDLE and fall on entry to GAP.
REQ-028 GAP SHALL hold txd=1 and de=0 for SILENCE_BITS times the latched divisor clocks.
REQ-029 GAP SHALL then pulse frame_done for one cycle and return to IDLE.
REQ-030 FIFO data arriving during GAP SHALL NOT be fetched until IDLE is reached.
REQ-031 tx_enable deasserted mid-byte SHALL let the current byte complete normally; the FSM then enters GAP.
REQ-032 No pop SHALL ever be issued while fifo_empty=1.
REQ-033 The bit counter SHALL be 4 bits and the divisor counter 16 bits; the GAP counter SHALL be wide enough for SILENCE_BITS*65535 clocks without wrap.

Reset
REQ-034 n_reset low SHALL immediately force IDLE, txd=1, de=0, fifo_rd_en=0, busy=0 and frame_done=0, and clear all counters.
REQ-035 Reset mid-byte SHALL abort the byte with no partial resumption after release.
REQ-036 The first state change after release SHALL be on the first rising clk edge with n_reset high.

Verification
REQ-037 baud_div=16, parity off, FIFO holds 0xA5 -> one fifo_rd_en; txd = 0,1,0,1,0,0,1,0,1,1 at 16 clocks/bit; de high throughout; frame_done 39*16 clocks after the stop bit ends.
REQ-038 parity_en=1, parity_odd=0, byte 0x07 -> parity bit 1; with parity_odd=1 -> parity bit 0.
REQ-039 FIFO holds 3 bytes, baud_div=8 -> 3 pops spaced (10*8+2) clocks apart; de continuous; a single frame_done after the third byte.
REQ-040 baud_div=2 -> bit period 4 clocks; baud_div changed mid-frame -> bit period unchanged.
REQ-041 Assert n_reset during DATA bit 3 -> txd=1 and de=0 asynchronously; after release with fifo_empty=0, a fresh start bit follows the FETCH/LOAD cycles.
REQ-042 tx_enable dropped during byte 1 of 2 -> byte 1 completes; no second pop; GAP and frame_done follow.
